// File: rtl/issue_stage.sv
// Issue/rename stage: register file, rename tags, operand resolve, RS feed.
// Define ISSUE_COMMIT_BYPASS_EN to forward same-cycle commits into resolve.
module issue_stage #(
  parameter int TAG_W = 4,
  parameter int NREG  = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [5:0]       dec_op,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic [4:0]       dec_rd,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic [31:0]      dec_imm,
  input  logic [31:0]      dec_pc,
  input  logic             dec_is_c,
  input  logic [TAG_W-1:0] dec_rob_id,
  input  logic             rs_full,
  output logic             to_rs,
  output logic [5:0]       op_type,
  output logic             j_out,
  output logic             k_out,
  output logic [31:0]      vj_out,
  output logic [31:0]      vk_out,
  output logic [TAG_W-1:0] qj_out,
  output logic [TAG_W-1:0] qk_out,
  output logic [TAG_W-1:0] dest_out,
  output logic [31:0]      imm_out,
  output logic [31:0]      pc_out,
  output logic             is_c_out,
  input  logic             rs_to_rob,
  input  logic [TAG_W-1:0] rs_dest,
  input  logic [31:0]      rs_value,
  input  logic             lsb_to_rs,
  input  logic [TAG_W-1:0] lsb_rob_id,
  input  logic [31:0]      lsb_value,
  input  logic             commit_valid,
  input  logic [4:0]       commit_rd,
  input  logic [TAG_W-1:0] commit_rob_id,
  input  logic [31:0]      commit_value,
  input  logic             clear_all
);

  typedef struct packed {
    logic [5:0]       op;
    logic             j;
    logic             k;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [TAG_W-1:0] dest;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic             is_c;
  } ent_t;

  typedef struct packed {
    logic             rdy;
    logic [31:0]      v;
    logic [TAG_W-1:0] q;
  } opnd_t;

  logic [31:0]      val_q [NREG];
  logic [31:0]      val_d [NREG];
  logic [TAG_W-1:0] tag_q [NREG];
  logic [TAG_W-1:0] tag_d [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;
  logic             out_valid_q;
  logic             out_valid_d;
  ent_t             ent_q;
  ent_t             ent_d;

  opnd_t src1;
  opnd_t src2;
  opnd_t snp_j;
  opnd_t snp_k;
  logic  stall;
  logic  acc;

  // RS broadcast wins over LSB when both carry the same tag
  function automatic opnd_t catch_bcast(input logic [TAG_W-1:0] q);
    opnd_t o;
    o   = '0;
    o.q = q;
    if (rs_to_rob && rs_dest == q) begin
      o.rdy = 1'b1;
      o.v   = rs_value;
      o.q   = '0;
    end else if (lsb_to_rs && lsb_rob_id == q) begin
      o.rdy = 1'b1;
      o.v   = lsb_value;
      o.q   = '0;
    end
    return o;
  endfunction

  function automatic opnd_t resolve(
    input logic       use_r,
    input logic [4:0] r
  );
    opnd_t o;
    o = '0;
    if (!use_r || r == 5'd0) begin
      o.rdy = 1'b1;
    end else if (!busy_q[r]) begin
      o.rdy = 1'b1;
      o.v   = val_q[r];
    end else begin
      o = catch_bcast(tag_q[r]);
`ifdef ISSUE_COMMIT_BYPASS_EN
      if (!o.rdy && commit_valid && commit_rd == r &&
          commit_rob_id == tag_q[r]) begin
        o.rdy = 1'b1;
        o.v   = commit_value;
        o.q   = '0;
      end
`endif
    end
    return o;
  endfunction

`ifndef ISSUE_COMMIT_BYPASS_EN
  // a source only the commit port could satisfy waits one cycle
  function automatic logic commit_wait(
    input logic       use_r,
    input logic [4:0] r
  );
    logic [TAG_W-1:0] t;
    t = tag_q[r];
    return use_r && r != 5'd0 && busy_q[r] &&
           !(rs_to_rob && rs_dest == t) &&
           !(lsb_to_rs && lsb_rob_id == t) &&
           commit_valid && commit_rd == r && commit_rob_id == t;
  endfunction
`endif

  assign src1  = resolve(dec_use_rs1, dec_rs1);
  assign src2  = resolve(dec_use_rs2, dec_rs2);
  assign snp_j = catch_bcast(ent_q.qj);
  assign snp_k = catch_bcast(ent_q.qk);

`ifdef ISSUE_COMMIT_BYPASS_EN
  assign stall = 1'b0;
`else
  assign stall = commit_wait(dec_use_rs1, dec_rs1) |
                 commit_wait(dec_use_rs2, dec_rs2);
`endif

  assign dec_ready = !rst_in && rdy_in && !clear_all &&
                     (!out_valid_q || !rs_full) && !stall;
  assign to_rs     = rdy_in && out_valid_q && !rs_full && !clear_all;
  assign acc       = dec_valid && dec_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    ent_d       = ent_q;
    busy_d      = busy_q;
    val_d       = val_q;
    tag_d       = tag_q;
    if (rdy_in) begin
      if (clear_all) begin
        out_valid_d = 1'b0;
      end else if (acc) begin
        out_valid_d = 1'b1;
        ent_d.op    = dec_op;
        ent_d.j     = src1.rdy;
        ent_d.vj    = src1.v;
        ent_d.qj    = src1.q;
        ent_d.k     = src2.rdy;
        ent_d.vk    = src2.v;
        ent_d.qk    = src2.q;
        ent_d.dest  = dec_rob_id;
        ent_d.imm   = dec_imm;
        ent_d.pc    = dec_pc;
        ent_d.is_c  = dec_is_c;
      end else if (to_rs) begin
        out_valid_d = 1'b0;
      end else if (out_valid_q) begin
        if (!ent_q.j && snp_j.rdy) begin
          ent_d.j  = 1'b1;
          ent_d.vj = snp_j.v;
          ent_d.qj = snp_j.q;
        end
        if (!ent_q.k && snp_k.rdy) begin
          ent_d.k  = 1'b1;
          ent_d.vk = snp_k.v;
          ent_d.qk = snp_k.q;
        end
      end
      if (commit_valid && commit_rd != 5'd0) begin
        val_d[commit_rd] = commit_value;
        if (tag_q[commit_rd] == commit_rob_id &&
            !(acc && dec_rd == commit_rd))
          busy_d[commit_rd] = 1'b0;
      end
      if (acc && dec_rd != 5'd0) begin
        busy_d[dec_rd] = 1'b1;
        tag_d[dec_rd]  = dec_rob_id;
      end
      if (clear_all)
        busy_d = '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_valid_q <= 1'b0;
      ent_q       <= '0;
      busy_q      <= '0;
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      ent_q       <= ent_d;
      busy_q      <= busy_d;
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= val_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign op_type  = ent_q.op;
  assign j_out    = ent_q.j;
  assign k_out    = ent_q.k;
  assign vj_out   = ent_q.vj;
  assign vk_out   = ent_q.vk;
  assign qj_out   = ent_q.qj;
  assign qk_out   = ent_q.qk;
  assign dest_out = ent_q.dest;
  assign imm_out  = ent_q.imm;
  assign pc_out   = ent_q.pc;
  assign is_c_out = ent_q.is_c;

endmodule

// File: tb/tb_issue_stage.sv
// Self-checking bench for issue_stage: directed scenarios plus
// randomized traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_issue_stage;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_in, rdy_in, dec_valid, dec_ready;
  logic [5:0] dec_op;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic dec_use_rs1, dec_use_rs2, dec_is_c;
  logic [31:0] dec_imm, dec_pc;
  logic [TW-1:0] dec_rob_id;
  logic rs_full, to_rs;
  logic [5:0] op_type;
  logic j_out, k_out, is_c_out;
  logic [31:0] vj_out, vk_out, imm_out, pc_out;
  logic [TW-1:0] qj_out, qk_out, dest_out;
  logic rs_to_rob, lsb_to_rs, commit_valid, clear_all;
  logic [TW-1:0] rs_dest, lsb_rob_id, commit_rob_id;
  logic [31:0] rs_value, lsb_value, commit_value;
  logic [4:0] commit_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  issue_stage #(.TAG_W(TW), .NREG(32)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_imm(dec_imm), .dec_pc(dec_pc), .dec_is_c(dec_is_c),
    .dec_rob_id(dec_rob_id), .rs_full(rs_full), .to_rs(to_rs),
    .op_type(op_type), .j_out(j_out), .k_out(k_out),
    .vj_out(vj_out), .vk_out(vk_out), .qj_out(qj_out), .qk_out(qk_out),
    .dest_out(dest_out), .imm_out(imm_out), .pc_out(pc_out),
    .is_c_out(is_c_out), .rs_to_rob(rs_to_rob), .rs_dest(rs_dest),
    .rs_value(rs_value), .lsb_to_rs(lsb_to_rs), .lsb_rob_id(lsb_rob_id),
    .lsb_value(lsb_value), .commit_valid(commit_valid),
    .commit_rd(commit_rd), .commit_rob_id(commit_rob_id),
    .commit_value(commit_value), .clear_all(clear_all)
  );

  // reference model: architectural state and the one pending issue slot
  logic [31:0]   m_val [32];
  logic [TW-1:0] m_tag [32];
  logic [31:0]   m_busy;
  bit            e_valid;
  logic [148:0]  e_ent;
  bit            e_j, e_k;
  logic [31:0]   e_vj, e_vk;
  logic [TW-1:0] e_qj, e_qk;
  logic [5:0]    e_op;
  logic [TW-1:0] e_dest;
  logic [31:0]   e_imm, e_pc;
  bit            e_c;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0;
      m_tag[i] = '0;
    end
    m_busy = '0;
    e_valid = 0;
  endtask

  task automatic m_resolve(input bit u, input logic [4:0] r,
                           output bit rd_o, output logic [31:0] v,
                           output logic [TW-1:0] q, output bit st);
    rd_o = 0; v = '0; q = '0; st = 0;
    if (!u || r == 0) rd_o = 1;
    else if (!m_busy[r]) begin rd_o = 1; v = m_val[r]; end
    else if (rs_to_rob && rs_dest == m_tag[r]) begin
      rd_o = 1; v = rs_value;
    end else if (lsb_to_rs && lsb_rob_id == m_tag[r]) begin
      rd_o = 1; v = lsb_value;
    end else if (commit_valid && commit_rd == r &&
                 commit_rob_id == m_tag[r]) begin
`ifdef ISSUE_COMMIT_BYPASS_EN
      rd_o = 1; v = commit_value;
`else
      q = m_tag[r]; st = 1;
`endif
    end else q = m_tag[r];
  endtask

  task automatic idle();
    rdy_in = 1; dec_valid = 0; dec_op = 0; dec_rs1 = 0; dec_rs2 = 0;
    dec_rd = 0; dec_use_rs1 = 0; dec_use_rs2 = 0; dec_imm = 0;
    dec_pc = 0; dec_is_c = 0; dec_rob_id = 0; rs_full = 0;
    rs_to_rob = 0; rs_dest = 0; rs_value = 0; lsb_to_rs = 0;
    lsb_rob_id = 0; lsb_value = 0; commit_valid = 0; commit_rd = 0;
    commit_rob_id = 0; commit_value = 0; clear_all = 0;
  endtask

  // one clock: compare outputs mid-cycle, advance model at the edge
  task automatic step(input string nm);
    bit r1, r2, s1, s2, xr, xt, acc;
    logic [31:0] v1, v2;
    logic [TW-1:0] q1, q2;
    logic [148:0] got, exp;
    int bad_v, bad_t;
    m_resolve(dec_use_rs1, dec_rs1, r1, v1, q1, s1);
    m_resolve(dec_use_rs2, dec_rs2, r2, v2, q2, s2);
    xr = rdy_in && !clear_all && (!e_valid || !rs_full) && !(s1 || s2);
    xt = rdy_in && e_valid && !rs_full && !clear_all;
    @(negedge clk);
    checks++;
    if (dec_ready !== xr) begin
      failures++;
      $display("FAIL %s dec_ready got %b exp %b", nm, dec_ready, xr);
    end
    checks++;
    if (to_rs !== xt) begin
      failures++;
      $display("FAIL %s to_rs got %b exp %b", nm, to_rs, xt);
    end
    if (e_valid) begin
      got = {op_type, j_out, k_out, vj_out, vk_out, qj_out, qk_out,
             dest_out, imm_out, pc_out, is_c_out};
      exp = {e_op, e_j, e_k, e_vj, e_vk, e_qj, e_qk,
             e_dest, e_imm, e_pc, e_c};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL %s entry got %h exp %h", nm, got, exp);
      end
    end
    @(posedge clk);
    acc = dec_valid && xr;
    if (rdy_in) begin
      if (clear_all) e_valid = 0;
      else if (acc) begin
        e_valid = 1; e_op = dec_op; e_dest = dec_rob_id;
        e_imm = dec_imm; e_pc = dec_pc; e_c = dec_is_c;
        e_j = r1; e_vj = v1; e_qj = q1;
        e_k = r2; e_vk = v2; e_qk = q2;
      end else if (xt) e_valid = 0;
      else if (e_valid) begin
        if (!e_j && rs_to_rob && rs_dest == e_qj) begin
          e_j = 1; e_vj = rs_value; e_qj = 0;
        end else if (!e_j && lsb_to_rs && lsb_rob_id == e_qj) begin
          e_j = 1; e_vj = lsb_value; e_qj = 0;
        end
        if (!e_k && rs_to_rob && rs_dest == e_qk) begin
          e_k = 1; e_vk = rs_value; e_qk = 0;
        end else if (!e_k && lsb_to_rs && lsb_rob_id == e_qk) begin
          e_k = 1; e_vk = lsb_value; e_qk = 0;
        end
      end
      if (commit_valid && commit_rd != 0) begin
        m_val[commit_rd] = commit_value;
        if (m_tag[commit_rd] == commit_rob_id &&
            !(acc && dec_rd == commit_rd))
          m_busy[commit_rd] = 0;
      end
      if (acc && dec_rd != 0) begin
        m_busy[dec_rd] = 1;
        m_tag[dec_rd] = dec_rob_id;
      end
      if (clear_all) m_busy = '0;
    end
    #1;
    checks++;
    if (dut.busy_q !== m_busy) begin
      failures++;
      $display("FAIL %s busy got %h exp %h", nm, dut.busy_q, m_busy);
    end
    bad_v = 0; bad_t = 0;
    for (int i = 0; i < 32; i++) begin
      if (dut.val_q[i] !== m_val[i]) bad_v++;
      if (dut.tag_q[i] !== m_tag[i]) bad_t++;
    end
    checks++;
    if (bad_v != 0) begin
      failures++;
      $display("FAIL %s reg_val got %0d bad entries exp 0", nm, bad_v);
    end
    checks++;
    if (bad_t != 0) begin
      failures++;
      $display("FAIL %s reg_tag got %0d bad entries exp 0", nm, bad_t);
    end
  endtask

  task automatic test_reset();
    logic [148:0] got;
    idle();
    rst_in = 1; dec_valid = 1;
    m_reset();
    #3;
    got = {op_type, j_out, k_out, vj_out, vk_out, qj_out, qk_out,
           dest_out, imm_out, pc_out, is_c_out};
    checks++;
    if (dec_ready !== 1'b0 || to_rs !== 1'b0) begin
      failures++;
      $display("FAIL reset handshake got %b%b exp 00", dec_ready, to_rs);
    end
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL reset outputs got %h exp 0", got);
    end
    dec_valid = 0;
    @(negedge clk);
    rst_in = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rename_chain();
    idle();
    dec_valid = 1; dec_op = 6'd5; dec_rd = 5; dec_rob_id = 3;
    dec_use_rs1 = 1; dec_rs1 = 0; dec_imm = 32'd1;
    step("chain1");
    dec_op = 6'd0; dec_rs1 = 5; dec_rs2 = 5; dec_use_rs2 = 1;
    dec_rd = 6; dec_rob_id = 4;
    step("chain2");
    dec_valid = 0;
    checks++;
    if (j_out !== 0 || k_out !== 0 || qj_out !== 4'd3 ||
        qk_out !== 4'd3 || dest_out !== 4'd4) begin
      failures++;
      $display("FAIL chain fields got j%b k%b qj%0d qk%0d d%0d exp j0 k0 qj3 qk3 d4",
               j_out, k_out, qj_out, qk_out, dest_out);
    end
    checks++;
    if (dut.busy_q[5] !== 1 || dut.busy_q[6] !== 1) begin
      failures++;
      $display("FAIL chain busy56 got %b%b exp 11",
               dut.busy_q[5], dut.busy_q[6]);
    end
  endtask

  task automatic test_bypass();
    idle();
    dec_valid = 1; dec_op = 6'd3; dec_rs1 = 5; dec_use_rs1 = 1;
    dec_rd = 7; dec_rob_id = 5;
    rs_to_rob = 1; rs_dest = 3; rs_value = 32'h1234;
    step("bypass");
    idle();
    checks++;
    if (j_out !== 1 || vj_out !== 32'h1234) begin
      failures++;
      $display("FAIL bypass j/vj got %b/%h exp 1/00001234", j_out, vj_out);
    end
  endtask

  task automatic test_hold_snoop();
    idle();
    dec_valid = 1; dec_op = 6'd4; dec_rs1 = 5; dec_use_rs1 = 1;
    dec_rd = 8; dec_rob_id = 6;
    step("hold_acc");
    dec_valid = 0; rs_full = 1;
    step("hold1");
    lsb_to_rs = 1; lsb_rob_id = 3; lsb_value = 32'd7;
    step("hold2");
    lsb_to_rs = 0;
    step("hold3");
    rs_full = 0;
    #1;
    checks++;
    if (to_rs !== 1 || j_out !== 1 || vj_out !== 32'd7) begin
      failures++;
      $display("FAIL hold release got to_rs%b j%b vj%h exp 1 1 00000007",
               to_rs, j_out, vj_out);
    end
    step("release");
    checks++;
    if (to_rs !== 0) begin
      failures++;
      $display("FAIL hold single to_rs got %b exp 0", to_rs);
    end
  endtask

  task automatic test_commit_race();
    idle();
    commit_valid = 1; commit_rd = 5; commit_rob_id = 3; commit_value = 9;
    dec_valid = 1; dec_rd = 5; dec_rob_id = 6; dec_op = 6'd1;
    step("race");
    idle();
    checks++;
    if (dut.val_q[5] !== 32'd9 || dut.busy_q[5] !== 1 ||
        dut.tag_q[5] !== 4'd6) begin
      failures++;
      $display("FAIL race x5 got val%0d busy%b tag%0d exp 9 1 6",
               dut.val_q[5], dut.busy_q[5], dut.tag_q[5]);
    end
  endtask

  task automatic test_flush();
    idle();
    rs_full = 1; clear_all = 1;
    step("flush");
    idle();
    checks++;
    if (to_rs !== 0 || dut.busy_q !== '0) begin
      failures++;
      $display("FAIL flush got to_rs%b busy%h exp 0 0", to_rs, dut.busy_q);
    end
    dec_valid = 1; dec_rs1 = 5; dec_rs2 = 6; dec_use_rs1 = 1;
    dec_use_rs2 = 1; dec_rd = 9; dec_rob_id = 7;
    step("flush_read");
    idle();
    checks++;
    if (j_out !== 1 || k_out !== 1 || vj_out !== 32'd9 || vk_out !== 0) begin
      failures++;
      $display("FAIL flush read got j%b k%b vj%0d vk%0d exp 1 1 9 0",
               j_out, k_out, vj_out, vk_out);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 0; i < 6; i++) begin
      dec_valid = 1; dec_op = 6'($urandom_range(0, 36));
      dec_rs1 = 5'($urandom_range(0, 9)); dec_use_rs1 = 1;
      dec_rs2 = 5'($urandom_range(0, 9)); dec_use_rs2 = 1;
      dec_rd = 5'($urandom_range(0, 9)); dec_rob_id = TW'(i + 8);
      dec_imm = $urandom; dec_pc = $urandom;
      #1;
      checks++;
      if (dec_ready !== 1) begin
        failures++;
        $display("FAIL b2b[%0d] dec_ready got %b exp 1", i, dec_ready);
      end
      step("b2b");
    end
    idle();
    step("b2b_drain");
  endtask

  task automatic test_reset_mid_hold();
    idle();
    dec_valid = 1; dec_rs1 = 3; dec_use_rs1 = 1; dec_rd = 4;
    dec_rob_id = 2;
    step("mh_acc");
    dec_valid = 0; rs_full = 1;
    step("mh_hold");
    #1 rst_in = 1;
    #1;
    checks++;
    if (to_rs !== 0 || dut.out_valid_q !== 0 || dest_out !== 0) begin
      failures++;
      $display("FAIL mid-hold reset got to_rs%b ov%b dest%0d exp 0 0 0",
               to_rs, dut.out_valid_q, dest_out);
    end
    #1 rst_in = 0;
    m_reset();
    idle();
    step("post_reset");
    checks++;
    if (dut.busy_q !== '0) begin
      failures++;
      $display("FAIL post-reset busy got %h exp 0", dut.busy_q);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rdy_in = ($urandom % 10) != 0;
      dec_valid = ($urandom % 4) != 0;
      dec_op = 6'($urandom_range(0, 36));
      dec_rs1 = 5'($urandom % 8); dec_rs2 = 5'($urandom % 8);
      dec_rd = 5'($urandom % 8);
      dec_use_rs1 = 1'($urandom); dec_use_rs2 = 1'($urandom);
      dec_imm = $urandom; dec_pc = $urandom; dec_is_c = 1'($urandom);
      dec_rob_id = TW'($urandom);
      rs_full = ($urandom % 3) == 0;
      rs_to_rob = ($urandom % 3) == 0; rs_dest = TW'($urandom);
      rs_value = $urandom;
      lsb_to_rs = ($urandom % 3) == 0; lsb_rob_id = TW'($urandom);
      lsb_value = $urandom;
      commit_valid = ($urandom % 3) == 0;
      commit_rd = 5'($urandom % 8);
      commit_rob_id = ($urandom % 2) ? m_tag[commit_rd] : TW'($urandom);
      commit_value = $urandom;
      clear_all = ($urandom % 25) == 0;
      step("random");
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_rename_chain();
    test_bypass();
    test_hold_snoop();
    test_commit_race();
    test_flush();
    test_back_to_back();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_stage.md
# issue_stage

Issue/rename stage that sits between the decoder and the reservation station (RS), producing the RS's decoder-side input port. It holds the architectural register file plus per-register rename tags (ROB ids). It resolves each instruction's source operands to either a value or a pending ROB tag, and forwards same-cycle RS, LSB and commit broadcasts so no result is missed. It presents one registered issue entry to the RS, held until the RS is not full.

## Interface
- TAG_W, default 4 (= `ROB_WIDTH_BIT`): ROB id / rename tag width.
- NREG, default 32: architectural registers; x0 hard-wired zero.
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous, active-high reset.
- rdy_in  in  1  global pause when low.
- dec_valid  in  1  decoder presents an instruction.
- dec_ready  out  1  instruction accepted at this edge when dec_valid is also high.
- dec_op  in  6  op code (RS encoding, 0..36).
- dec_rs1, dec_rs2, dec_rd  in  5  register indices.
- dec_use_rs1, dec_use_rs2  in  1  source is read.
- dec_imm, dec_pc  in  32  immediate, instruction PC.
- dec_is_c  in  1  compressed instruction.
- dec_rob_id  in  TAG_W  ROB entry allocated for this instruction.
- rs_full  in  1  RS cannot accept.
- to_rs  out  1  RS inserts the entry this cycle.
- op_type  out  6; j_out, k_out  out  1; vj_out, vk_out  out  32; qj_out, qk_out  out  TAG_W; dest_out  out  TAG_W; imm_out, pc_out  out  32; is_c_out  out  1.
- rs_to_rob  in  1; rs_dest  in  TAG_W; rs_value  in  32: RS result broadcast.
- lsb_to_rs  in  1; lsb_rob_id  in  TAG_W; lsb_value  in  32: LSB result broadcast.
- commit_valid  in  1; commit_rd  in  5; commit_rob_id  in  TAG_W; commit_value  in  32: ROB commit.
- clear_all  in  1: misprediction flush.

## Operation
- State: reg_val[NREG], reg_busy[NREG], reg_tag[NREG]; one issue register (out_valid plus all RS fields).
- Operand resolve at accept, per source s:
  - Source unused or r==0: ready, value 0.
  - Otherwise, if !busy[r]: ready, value = reg_val[r].
  - If busy[r] and a same-cycle match exists on tag[r], ready with that value. Matches are checked in priority order RS broadcast, then LSB broadcast, then commit (commit_rob_id==tag[r] with commit_rd==r).
  - Otherwise not ready, q = tag[r].
- Rename on accept with rd!=0: busy[rd]<=1, tag[rd]<=dec_rob_id.
- Commit with rd!=0: reg_val[rd]<=commit_value. busy[rd]<=0 only if tag[rd]==commit_rob_id and no same-cycle rename of rd; a same-cycle rename wins.
- dec_ready = rdy_in & !clear_all & (!out_valid | !rs_full).
- to_rs = rdy_in & out_valid & !rs_full & !clear_all.
- Accept loads the issue register. out_valid clears when to_rs fires with no new accept.
- Held entry snoops every cycle: any not-ready operand whose q matches an RS or LSB broadcast gets ready, value captured.
- clear_all: out_valid<=0, all busy<=0, tags unchanged, reg_val unchanged; no accept that cycle; commit write still applied.
- rdy_in low: no state change, to_rs=0, dec_ready=0.

## Timing
- Reset (async): out_valid=0, all reg_val=0, busy=0, tag=0. All outputs 0: to_rs, op_type, j/k, v/q, dest, imm, pc, is_c. dec_ready=0 while rst_in is high.
- Accept at edge N. Entry is visible from cycle N+1. to_rs rises in N+1 if !rs_full, and the RS inserts at edge N+2.
- Back-to-back: one instruction per cycle when the RS is never full.
- rs_full held: entry is held and snoops; dec_ready stays low. Entry is released the first cycle rs_full drops.
- Broadcast in the same cycle as to_rs for the held entry: the outputs carry the pre-snoop j/k/v/q, because the RS performs its own same-cycle LSB/RS capture.
- x0: never busy, never renamed, commit to x0 ignored.

## Configuration
- ISSUE_COMMIT_BYPASS_EN defined: same-cycle commit forwarding into operand resolve, as above.
- Undefined: if a same-cycle commit would satisfy a busy source, dec_ready is forced low for that cycle. The next cycle reads the committed reg_val.

## Test plan
- Reset mid-hold: out_valid=1, rs_full=1, assert rst_in asynchronously -> to_rs=0 and out_valid=0 immediately; busy all 0 after release.
- Rename chain: issue addi x5 (rob 3), then add x6,x5,x5 (rob 4) -> second entry j=k=0, qj=qk=3, dest_out=4, busy[5]=busy[6]=1.
- Same-cycle bypass: x5 busy tag 3; issue x5 reader while rs_to_rob=1, rs_dest=3, rs_value=0x1234 -> j_out=1, vj_out=0x1234.
- Hold and snoop: rs_full=1 for 3 cycles with qj=3 pending; lsb_to_rs=1, lsb_rob_id=3, lsb_value=7 in cycle 2 -> on release j_out=1, vj_out=7, to_rs for exactly one cycle.
- Commit/rename race: busy[5] tag 3; commit rob 3 to x5 value 9, same cycle rename x5 to rob 6 -> reg_val[5]=9, busy[5]=1, tag[5]=6.
- Flush: clear_all with out_valid=1 and 4 busy registers -> next cycle to_rs=0, all busy=0, a reader of those registers gets j=1 with reg_val.
